// File: rtl/program_load_sequencer.sv
// ---------------------------------------------------------------------------
// program_load_sequencer
//   Boot/run controller for the pipelined CPU core. Streams host bytes into
//   program memory over a valid/ready handshake while holding the CPU in
//   reset, then releases the CPU for a programmed number of cycles or lets
//   it free-run.
//
// Ports
//   clk, rst            clock (rising edge) / asynchronous active-low reset
//   load_req            start or restart a load (level, sampled each cycle)
//   load_len            bytes to load; 0 means 2^ADD_WIDTH
//   run_cycles          CPU run length after the load; 0 = free-run
//   byte_valid/_data    host byte stream
//   byte_ready          high while in LOAD (combinational)
//   pm_wr_en/addr/wdata program-memory byte write port (registered)
//   cpu_hold            1 = CPU held in reset
//   state               IDLE=0, LOAD=1, DRAIN=2, RUN=3
//   done                sticky flag: a timed run has completed
//   checksum            running byte sum of the current load
//
// Build option
//   LOADER_CHECKSUM_EN  when defined, checksum = sum mod 256 of the bytes
//                       accepted since LOAD entry; otherwise tied to 0.
// ---------------------------------------------------------------------------
module program_load_sequencer #(
    parameter int ADD_WIDTH  = 7,
    parameter int DATA_WIDTH = 8,
    parameter int RUN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic [ADD_WIDTH-1:0]  load_len,
    input  logic [RUN_WIDTH-1:0]  run_cycles,
    input  logic                  byte_valid,
    input  logic [DATA_WIDTH-1:0] byte_data,
    output logic                  byte_ready,
    output logic                  pm_wr_en,
    output logic [ADD_WIDTH-1:0]  pm_addr,
    output logic [DATA_WIDTH-1:0] pm_wdata,
    output logic                  cpu_hold,
    output logic [1:0]            state,
    output logic                  done,
    output logic [7:0]            checksum
);

    // Remaining count needs one extra bit to represent a full 2^ADD_WIDTH load.
    localparam int CNT_W = ADD_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_RUN   = 2'd3
    } state_e;

    state_e                state_q,    state_d;
    logic [CNT_W-1:0]      remain_q,   remain_d;
    logic [ADD_WIDTH-1:0]  addr_q,     addr_d;
    logic [RUN_WIDTH-1:0]  run_cnt_q,  run_cnt_d;
    logic                  done_q,     done_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  pm_wr_en_q, pm_wr_en_d;
    logic [ADD_WIDTH-1:0]  pm_addr_q,  pm_addr_d;
    logic [DATA_WIDTH-1:0] pm_wdata_q, pm_wdata_d;
    logic                  load_entry;
    logic                  hs;

    assign byte_ready = (state_q == S_LOAD);
    assign hs         = byte_valid & byte_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            remain_q   <= '0;
            addr_q     <= '0;
            run_cnt_q  <= '0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
            pm_wr_en_q <= 1'b0;
            pm_addr_q  <= '0;
            pm_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            addr_q     <= addr_d;
            run_cnt_q  <= run_cnt_d;
            done_q     <= done_d;
            cpu_hold_q <= cpu_hold_d;
            pm_wr_en_q <= pm_wr_en_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        run_cnt_d  = run_cnt_q;
        done_d     = done_q;
        load_entry = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d    = S_LOAD;
                    load_entry = 1'b1;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    addr_d   = addr_q + ADD_WIDTH'(1);
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                run_cnt_d = run_cycles;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // Abort wins over expiry; a zero count never expires (free-run).
                if (load_req) begin
                    state_d    = S_LOAD;
                    load_entry = 1'b1;
                end else if (run_cnt_q == RUN_WIDTH'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (run_cnt_q != '0) begin
                    run_cnt_d = run_cnt_q - RUN_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_entry) begin
            remain_d = (load_len == '0) ? {1'b1, {ADD_WIDTH{1'b0}}} : {1'b0, load_len};
            addr_d   = '0;
            done_d   = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Registered output logic
    // -----------------------------------------------------------------------
    always_comb begin
        pm_wr_en_d = hs;
        pm_addr_d  = hs ? addr_q    : pm_addr_q;
        pm_wdata_d = hs ? byte_data : pm_wdata_q;
        // Hold is derived from the next state so cpu_hold is low exactly
        // during the cycles the state register reads RUN.
        cpu_hold_d = (state_d != S_RUN);
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_entry)
            checksum_d = '0;
        else if (hs)
            checksum_d = checksum_q + 8'(byte_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) checksum_q <= '0;
        else      checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign state    = state_q;
    assign done     = done_q;
    assign cpu_hold = cpu_hold_q;
    assign pm_wr_en = pm_wr_en_q;
    assign pm_addr  = pm_addr_q;
    assign pm_wdata = pm_wdata_q;

endmodule

// File: tb/tb_program_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_load_sequencer
//   Directed + randomized bench. A behavioural memory model captures every
//   write pulse; expected writes, run lengths and checksums are computed
//   from the byte lists and run lengths handed to each step.
// ---------------------------------------------------------------------------
module tb_program_load_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_req = 1'b0;
    logic [6:0] load_len = '0;
    logic [7:0] run_cycles = '0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = '0;
    logic       byte_ready, pm_wr_en, cpu_hold, done;
    logic [6:0] pm_addr;
    logic [7:0] pm_wdata, checksum;
    logic [1:0] state;

    program_load_sequencer dut (
        .clk(clk), .rst(rst), .load_req(load_req), .load_len(load_len),
        .run_cycles(run_cycles), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .pm_wr_en(pm_wr_en), .pm_addr(pm_addr),
        .pm_wdata(pm_wdata), .cpu_hold(cpu_hold), .state(state), .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:127];
    int         wlog_a[$];
    int         wlog_d[$];
    logic [7:0] exp_bytes[$];

    // Program memory model: captures write pulses mid-cycle.
    always @(negedge clk) begin
        if (pm_wr_en === 1'b1) begin
            mem[pm_addr] = pm_wdata;
            wlog_a.push_back(int'(pm_addr));
            wlog_d.push_back(int'(pm_wdata));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_hold"},  32'(cpu_hold), 1);
        check({tag, "_ready"}, 32'(byte_ready), 0);
        check({tag, "_wren"},  32'(pm_wr_en), 0);
        check({tag, "_addr"},  32'(pm_addr), 0);
        check({tag, "_wdata"}, 32'(pm_wdata), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_csum"},  32'(checksum), 0);
    endtask

    function automatic int model_csum();
        int s = 0;
`ifdef LOADER_CHECKSUM_EN
        foreach (exp_bytes[i]) s += int'(exp_bytes[i]);
`endif
        return s % 256;
    endfunction

    // Load exp_bytes (1..128 of them), ending one cycle into RUN.
    // gap_mode: 0 back-to-back, 1 one idle cycle before every byte, 2 random gaps.
    task automatic do_load(input int gap_mode);
        int n = exp_bytes.size();
        int g;
        wlog_a.delete();
        wlog_d.delete();
        load_len = 7'(n % 128);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("entry_state", 32'(state), 1);
        check("entry_hold",  32'(cpu_hold), 1);
        check("entry_done",  32'(done), 0);
        check("entry_csum",  32'(checksum), 0);
        load_len = 7'($urandom);  // latched already; must not matter
        for (int i = 0; i < n; i++) begin
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                load_req   = 1'($urandom);
                tick();
                check("gap_ready", 32'(byte_ready), 1);
                check("gap_state", 32'(state), 1);
            end
            byte_valid = 1'b1;
            byte_data  = exp_bytes[i];
            load_req   = (i < n - 1) ? 1'($urandom) : 1'b0;
            tick();
            if (i < n - 1) begin
                check("load_ready", 32'(byte_ready), 1);
                check("load_state", 32'(state), 1);
            end
        end
        byte_valid = 1'b0;
        load_req   = 1'b0;
        check("drain_state", 32'(state), 2);
        check("drain_wren",  32'(pm_wr_en), 1);
        check("drain_addr",  32'(pm_addr), 32'(n - 1));
        check("drain_wdata", 32'(pm_wdata), 32'(exp_bytes[n-1]));
        check("drain_hold",  32'(cpu_hold), 1);
        check("drain_csum",  32'(checksum), 32'(model_csum()));
        tick();
        check("run_state", 32'(state), 3);
        check("run_hold",  32'(cpu_hold), 0);
        check("run_wren",  32'(pm_wr_en), 0);
        check("run_addr_hold", 32'(pm_addr), 32'(n - 1));
        check("wr_count", 32'(wlog_a.size()), 32'(n));
        for (int i = 0; i < n && i < wlog_a.size(); i++) begin
            check("wr_addr", 32'(wlog_a[i]), 32'(i));
            check("wr_data", 32'(wlog_d[i]), 32'(exp_bytes[i]));
            check("mem",     32'(mem[i]), 32'(exp_bytes[i]));
        end
    endtask

    // Count cycles with cpu_hold low from the current RUN cycle to expiry.
    task automatic run_timed(input int nexp);
        int cnt = 0;
        while (cpu_hold === 1'b0 && cnt < 1000) begin
            cnt++;
            tick();
        end
        check("run_len",    32'(cnt), 32'(nexp));
        check("post_state", 32'(state), 0);
        check("post_done",  32'(done), 1);
        check("post_hold",  32'(cpu_hold), 1);
    endtask

    initial begin
        logic [7:0] rb [0:2];
        int rl;

        // ---- reset values ----
        tick();
        tick();
        check_reset_vals("rst0");
        rst = 1'b1;
        tick();

        // ---- reset in the middle of a 5-byte load ----
        load_len = 7'd5;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rb[i]      = 8'($urandom);
            byte_valid = 1'b1;
            byte_data  = rb[i];
            tick();
        end
        byte_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1 check_reset_vals("rstmid");
        for (int i = 0; i < 3; i++) check("rst_mem_keep", 32'(mem[i]), 32'(rb[i]));
        tick();
        rst = 1'b1;
        tick();
        check("rst_stays_idle", 32'(state), 0);

        // ---- 4 bytes back-to-back, timed run of 10 ----
        exp_bytes = '{8'h13, 8'h05, 8'hA0, 8'h00};
        run_cycles = 8'd10;
        do_load(0);
        run_timed(10);

        // ---- bytes outside LOAD are ignored; done is sticky ----
        wlog_a.delete();
        repeat (3) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            tick();
            check("idle_ready", 32'(byte_ready), 0);
            check("idle_state", 32'(state), 0);
            check("idle_done",  32'(done), 1);
        end
        byte_valid = 1'b0;
        tick();
        check("idle_no_write", 32'(wlog_a.size()), 0);

        // ---- same load with toggling valid, then free-run and abort ----
        run_cycles = 8'd0;
        do_load(1);
        repeat (50) begin
            tick();
            check("free_hold",  32'(cpu_hold), 0);
            check("free_state", 32'(state), 3);
        end
        exp_bytes.delete();
        for (int i = 0; i < 128; i++) exp_bytes.push_back(8'($urandom));
        run_cycles = 8'd3;
        do_load(0);                     // load_len=0 -> 128 bytes, ends at 127
        run_timed(3);

        // ---- checksum of FF,02,10 ----
        exp_bytes = '{8'hFF, 8'h02, 8'h10};
        run_cycles = 8'd1;
        do_load(0);
`ifdef LOADER_CHECKSUM_EN
        check("csum_const", 32'(checksum), 32'h11);
`else
        check("csum_const", 32'(checksum), 32'h0);
`endif
        run_timed(1);

        // ---- abort on the last RUN cycle: load_req beats expiry ----
        exp_bytes = '{8'h5A, 8'hC3};
        run_cycles = 8'd5;
        do_load(0);
        repeat (4) tick();
        check("last_run_state", 32'(state), 3);
        exp_bytes = '{8'h11, 8'h22, 8'h33};
        run_cycles = 8'd2;
        do_load(2);
        run_timed(2);

        // ---- randomized loads and runs ----
        repeat (6) begin
            exp_bytes.delete();
            rl = $urandom_range(1, 24);
            for (int i = 0; i < rl; i++) exp_bytes.push_back(8'($urandom));
            rl = $urandom_range(1, 15);
            run_cycles = 8'(rl);
            do_load(2);
            run_timed(rl);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
